forward_history_updater: RTL
============================

Name: forward_history_updater

Overview:
- Multi-entry successor of the single-stage write-back forwarder in the cuckoo-hash insert/lookup pipeline.
- Corrects a stale memory read (key, data, valid, shift address, shift valid) against the current write-back and the last FWD_DEPTH write-backs of its own table memory.
- Corrects the shift-valid flag against the last FWD_DEPTH write-backs of the next table memory.
- Result is registered (1-cycle latency) and stallable; sits between memory read stage and the compare/displace stage of each table.

Parameters:
DATA_WIDTH, 4, payload width
KEY_WIDTH, 2, key width
HASH_ADR_WIDTH, 2, address width of this table memory
SHIFT_HASH_ADR_WIDTH, 2, address width of the next table memory
FWD_DEPTH, 3, stored history entries per memory (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
clk_en  in  1  pipeline advance; low = full stall
flush_i  in  1  invalidate all history entries
new_req_i  in  1  lookup present this cycle
new_hash_adr_i  in  HASH_ADR_WIDTH  address that was read
new_key_i  in  KEY_WIDTH  read key
new_data_i  in  DATA_WIDTH  read data
new_valid_i  in  1  read slot valid
new_shift_adr_i  in  SHIFT_HASH_ADR_WIDTH  read entry's address in next table
new_shift_valid_i  in  1  read next-table slot valid
wb_updated_mem_i  in  1  write-back to this memory occurs this cycle
wb_hash_adr_i  in  HASH_ADR_WIDTH  write-back address
wb_key_i  in  KEY_WIDTH  write-back key
wb_data_i  in  DATA_WIDTH  write-back data
wb_valid_i  in  1  write-back valid bit
wb_shift_hash_adr_i  in  SHIFT_HASH_ADR_WIDTH  write-back shift address
wb_shift_valid_i  in  1  write-back shift valid
nm_updated_i  in  1  write-back to next memory this cycle
nm_hash_adr_i  in  SHIFT_HASH_ADR_WIDTH  next-memory write address
nm_valid_i  in  1  next-memory written valid bit
correct_req_o  out  1  registered new_req_i
correct_key  out  KEY_WIDTH  corrected key
correct_data  out  DATA_WIDTH  corrected data
correct_is_valid  out  1  corrected valid
correct_shift_hash_adr  out  SHIFT_HASH_ADR_WIDTH  corrected shift address
correct_shift_valid  out  1  corrected shift valid
fwd_hit_o  out  1  first-stage forward taken
shift_fwd_hit_o  out  1  shift-valid forward taken

Behaviour:
- Reset (reset=0, async): all history entries and tags 0; all outputs 0.
- History: two cycle-aligned shift registers, index 0 newest.
  - Own memory: tag, adr, key, data, valid, shift adr, shift valid.
  - Next memory: tag, adr, valid.
- Each clk_en=1 edge both registers shift by one; oldest entry is dropped.
  - Slot 0 loads the current wb_*/nm_* fields, with tag = wb_updated_mem_i / nm_updated_i.
  - An entry therefore ages exactly one slot per advanced cycle.
- clk_en=0: history and outputs hold. Inputs that cycle are ignored, including wb/nm updates; the controller stalls writes together with clk_en.
- flush_i=1 on any edge clears all tags, independent of clk_en.
  - If clk_en=1 too, slot 0 is also loaded with tag 0: flush wins over a same-cycle write-back.
  - The lookup is still registered and still sees the same-cycle bypass.
  - A flush with clk_en=0 clears tags but does not update outputs.
- First-stage match, combinational, priority newest-first:
  - (a) bypass when wb_updated_mem_i=1 and wb_hash_adr_i==new_hash_adr_i;
  - (b) otherwise the lowest-index slot with tag=1 and matching adr;
  - (c) otherwise pass new_*.
  - Selected source supplies key, data, valid, shift adr, shift valid.
  - fwd_hit = (a) or (b).
- Second-stage match uses the first-stage shift adr, same newest-first rule:
  - nm bypass (nm_updated_i=1 and address equal), then nm history slots;
  - a hit replaces only shift valid, with the entry's valid. Shift address is never replaced by this stage.
- All results registered on clk_en=1; latency exactly 1 cycle.
  - When new_req_i=0 the data outputs still register the computed values; correct_req_o=0 marks them don't-care.
- Duplicate addresses in history: only the newest counts.
- Address compare is full-width equality; no hashing inside the block.

Decomposition:
- Shared package hash_fwd_pkg:
  - packed struct fwd_entry_t {tag, adr, key, data, valid, shift_adr, shift_valid};
  - struct nm_entry_t {tag, adr, valid};
  - typedef'd widths via parameterised types in the instantiating module.
- Natural sub-module fwd_priority_match: FWD_DEPTH+1 candidates in, one-hot oldest-masked select plus hit out. Instantiated twice, for the own-memory and next-memory searches.

Test Plan:
- Reset, then a lookup of adr 2 with empty history. One cycle later the outputs equal new_* and fwd_hit_o=0.
- Same-cycle bypass: wb adr 1 key 3 data 9 valid 1, with a lookup of adr 1 carrying stale key 0. Next cycle correct_key=3, correct_data=9, fwd_hit_o=1.
- Aging: write adr 1 data 5, then write adr 1 data 7 one cycle later, then lookup adr 1 at cycle +2.
  - data=7 (newest wins).
  - After FWD_DEPTH further idle cycles, a lookup of adr 1 returns new_data_i (entry aged out).
- Stall: write adr 0 data 6, hold clk_en=0 for 5 cycles, then lookup adr 0 on the first clk_en=1 cycle. data=6 and outputs are unchanged during the stall.
- Flush: write adr 3, assert flush_i together with a wb to adr 2, then look up adr 3 and adr 2. Both return new_*, and neither fwd_hit_o nor shift_fwd_hit_o is set.
- Shift chain: nm write adr 2 valid 0 one cycle earlier; wb adr 1 with shift adr 2, shift valid 1; lookup adr 1. Result: shift_hash_adr=2, correct_shift_valid=0, both hit flags 1.
- Async reset asserted mid-stream: outputs drop to 0 immediately without a clock edge, and history is empty afterwards.

Source files
------------

// File: rtl/hash_fwd_pkg.sv
// Shared defaults for the cuckoo-hash write-back forwarding blocks.
package hash_fwd_pkg;

   localparam int DEF_DATA_WIDTH           = 4;
   localparam int DEF_KEY_WIDTH            = 2;
   localparam int DEF_HASH_ADR_WIDTH       = 2;
   localparam int DEF_SHIFT_HASH_ADR_WIDTH = 2;
   localparam int DEF_FWD_DEPTH            = 3;

endpackage

// File: rtl/forward_history_updater_if.sv
// Lookup, write-back and corrected-result signals between a table read stage and its forwarder.
interface forward_history_updater_if
   import hash_fwd_pkg::*;
#(
   parameter int DATA_WIDTH           = DEF_DATA_WIDTH,
   parameter int KEY_WIDTH            = DEF_KEY_WIDTH,
   parameter int HASH_ADR_WIDTH       = DEF_HASH_ADR_WIDTH,
   parameter int SHIFT_HASH_ADR_WIDTH = DEF_SHIFT_HASH_ADR_WIDTH
);

   logic                            new_req_i;
   logic [HASH_ADR_WIDTH-1:0]       new_hash_adr_i;
   logic [KEY_WIDTH-1:0]            new_key_i;
   logic [DATA_WIDTH-1:0]           new_data_i;
   logic                            new_valid_i;
   logic [SHIFT_HASH_ADR_WIDTH-1:0] new_shift_adr_i;
   logic                            new_shift_valid_i;

   logic                            wb_updated_mem_i;
   logic [HASH_ADR_WIDTH-1:0]       wb_hash_adr_i;
   logic [KEY_WIDTH-1:0]            wb_key_i;
   logic [DATA_WIDTH-1:0]           wb_data_i;
   logic                            wb_valid_i;
   logic [SHIFT_HASH_ADR_WIDTH-1:0] wb_shift_hash_adr_i;
   logic                            wb_shift_valid_i;

   logic                            nm_updated_i;
   logic [SHIFT_HASH_ADR_WIDTH-1:0] nm_hash_adr_i;
   logic                            nm_valid_i;

   logic                            correct_req_o;
   logic [KEY_WIDTH-1:0]            correct_key;
   logic [DATA_WIDTH-1:0]           correct_data;
   logic                            correct_is_valid;
   logic [SHIFT_HASH_ADR_WIDTH-1:0] correct_shift_hash_adr;
   logic                            correct_shift_valid;
   logic                            fwd_hit_o;
   logic                            shift_fwd_hit_o;

   modport master (
      output new_req_i, new_hash_adr_i, new_key_i, new_data_i, new_valid_i,
             new_shift_adr_i, new_shift_valid_i,
             wb_updated_mem_i, wb_hash_adr_i, wb_key_i, wb_data_i, wb_valid_i,
             wb_shift_hash_adr_i, wb_shift_valid_i,
             nm_updated_i, nm_hash_adr_i, nm_valid_i,
      input  correct_req_o, correct_key, correct_data, correct_is_valid,
             correct_shift_hash_adr, correct_shift_valid, fwd_hit_o, shift_fwd_hit_o
   );

   modport slave (
      input  new_req_i, new_hash_adr_i, new_key_i, new_data_i, new_valid_i,
             new_shift_adr_i, new_shift_valid_i,
             wb_updated_mem_i, wb_hash_adr_i, wb_key_i, wb_data_i, wb_valid_i,
             wb_shift_hash_adr_i, wb_shift_valid_i,
             nm_updated_i, nm_hash_adr_i, nm_valid_i,
      output correct_req_o, correct_key, correct_data, correct_is_valid,
             correct_shift_hash_adr, correct_shift_valid, fwd_hit_o, shift_fwd_hit_o
   );

endinterface

// File: rtl/forward_history_updater_match.sv
// Newest-first address match over a candidate list; index 0 is the newest candidate.
module fwd_priority_match
   import hash_fwd_pkg::*;
#(
   parameter int N         = DEF_FWD_DEPTH + 1,
   parameter int ADR_WIDTH = DEF_HASH_ADR_WIDTH
)(
   input  logic [N-1:0]         cand_tag,
   input  logic [ADR_WIDTH-1:0] cand_adr [N],
   input  logic [ADR_WIDTH-1:0] key_adr,
   output logic [N-1:0]         sel,
   output logic                 hit
);

   logic [N-1:0] match;
   logic         found;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         match[i] = cand_tag[i] && (cand_adr[i] == key_adr);
      end
   end

   // Older duplicates are masked once a newer candidate has matched.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (match[i] && !found) begin
            sel[i] = 1'b1;
            found  = 1'b1;
         end
      end
      hit = found;
   end

endmodule

// File: rtl/forward_history_updater.sv
// Corrects a stale table read against the live write-back and a FWD_DEPTH-deep write-back history.
module forward_history_updater
   import hash_fwd_pkg::*;
#(
   parameter int DATA_WIDTH           = DEF_DATA_WIDTH,
   parameter int KEY_WIDTH            = DEF_KEY_WIDTH,
   parameter int HASH_ADR_WIDTH       = DEF_HASH_ADR_WIDTH,
   parameter int SHIFT_HASH_ADR_WIDTH = DEF_SHIFT_HASH_ADR_WIDTH,
   parameter int FWD_DEPTH            = DEF_FWD_DEPTH
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clk_en,
   input  logic                     flush_i,
   forward_history_updater_if.slave bus
);

   localparam int NCAND = FWD_DEPTH + 1;

   typedef struct packed {
      logic                            tag;
      logic [HASH_ADR_WIDTH-1:0]       adr;
      logic [KEY_WIDTH-1:0]            key;
      logic [DATA_WIDTH-1:0]           data;
      logic                            valid;
      logic [SHIFT_HASH_ADR_WIDTH-1:0] shift_adr;
      logic                            shift_valid;
   } fwd_entry_t;

   typedef struct packed {
      logic                            tag;
      logic [SHIFT_HASH_ADR_WIDTH-1:0] adr;
      logic                            valid;
   } nm_entry_t;

   fwd_entry_t fwd_hist [FWD_DEPTH];
   nm_entry_t  nm_hist  [FWD_DEPTH];

   fwd_entry_t wb_entry;
   nm_entry_t  nm_entry;
   fwd_entry_t own_cand [NCAND];
   nm_entry_t  nm_cand  [NCAND];

   logic [NCAND-1:0]                own_tag, nm_tag;
   logic [HASH_ADR_WIDTH-1:0]       own_adr [NCAND];
   logic [SHIFT_HASH_ADR_WIDTH-1:0] nm_adr  [NCAND];
   logic [NCAND-1:0]                own_sel, nm_sel;
   logic                            own_hit, nm_hit;

   logic [KEY_WIDTH-1:0]            sel_key;
   logic [DATA_WIDTH-1:0]           sel_data;
   logic                            sel_valid;
   logic [SHIFT_HASH_ADR_WIDTH-1:0] sel_shift_adr;
   logic                            sel_shift_valid;
   logic                            fin_shift_valid;

   always_comb begin
      wb_entry = '{tag:         bus.wb_updated_mem_i,
                   adr:         bus.wb_hash_adr_i,
                   key:         bus.wb_key_i,
                   data:        bus.wb_data_i,
                   valid:       bus.wb_valid_i,
                   shift_adr:   bus.wb_shift_hash_adr_i,
                   shift_valid: bus.wb_shift_valid_i};
      nm_entry = '{tag:   bus.nm_updated_i,
                   adr:   bus.nm_hash_adr_i,
                   valid: bus.nm_valid_i};
   end

   // Candidate 0 is the same-cycle bypass, followed by history slots newest-first.
   always_comb begin
      own_cand[0] = wb_entry;
      nm_cand[0]  = nm_entry;
      for (int i = 0; i < FWD_DEPTH; i++) begin
         own_cand[i+1] = fwd_hist[i];
         nm_cand[i+1]  = nm_hist[i];
      end
      for (int i = 0; i < NCAND; i++) begin
         own_tag[i] = own_cand[i].tag;
         own_adr[i] = own_cand[i].adr;
         nm_tag[i]  = nm_cand[i].tag;
         nm_adr[i]  = nm_cand[i].adr;
      end
   end

   fwd_priority_match #(
      .N         (NCAND),
      .ADR_WIDTH (HASH_ADR_WIDTH)
   ) u_own_match (
      .cand_tag (own_tag),
      .cand_adr (own_adr),
      .key_adr  (bus.new_hash_adr_i),
      .sel      (own_sel),
      .hit      (own_hit)
   );

   always_comb begin
      sel_key         = bus.new_key_i;
      sel_data        = bus.new_data_i;
      sel_valid       = bus.new_valid_i;
      sel_shift_adr   = bus.new_shift_adr_i;
      sel_shift_valid = bus.new_shift_valid_i;
      for (int i = 0; i < NCAND; i++) begin
         if (own_sel[i]) begin
            sel_key         = own_cand[i].key;
            sel_data        = own_cand[i].data;
            sel_valid       = own_cand[i].valid;
            sel_shift_adr   = own_cand[i].shift_adr;
            sel_shift_valid = own_cand[i].shift_valid;
         end
      end
   end

   // The next-table search keys off the already-corrected shift address.
   fwd_priority_match #(
      .N         (NCAND),
      .ADR_WIDTH (SHIFT_HASH_ADR_WIDTH)
   ) u_nm_match (
      .cand_tag (nm_tag),
      .cand_adr (nm_adr),
      .key_adr  (sel_shift_adr),
      .sel      (nm_sel),
      .hit      (nm_hit)
   );

   always_comb begin
      fin_shift_valid = sel_shift_valid;
      for (int i = 0; i < NCAND; i++) begin
         if (nm_sel[i]) begin
            fin_shift_valid = nm_cand[i].valid;
         end
      end
   end

   // Flush clears tags after the shift so it also kills a same-cycle slot-0 load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FWD_DEPTH; i++) begin
            fwd_hist[i] <= '0;
            nm_hist[i]  <= '0;
         end
         bus.correct_req_o          <= 1'b0;
         bus.correct_key            <= '0;
         bus.correct_data           <= '0;
         bus.correct_is_valid       <= 1'b0;
         bus.correct_shift_hash_adr <= '0;
         bus.correct_shift_valid    <= 1'b0;
         bus.fwd_hit_o              <= 1'b0;
         bus.shift_fwd_hit_o        <= 1'b0;
      end else begin
         if (clk_en) begin
            for (int i = FWD_DEPTH - 1; i > 0; i--) begin
               fwd_hist[i] <= fwd_hist[i-1];
               nm_hist[i]  <= nm_hist[i-1];
            end
            fwd_hist[0] <= wb_entry;
            nm_hist[0]  <= nm_entry;

            bus.correct_req_o          <= bus.new_req_i;
            bus.correct_key            <= sel_key;
            bus.correct_data           <= sel_data;
            bus.correct_is_valid       <= sel_valid;
            bus.correct_shift_hash_adr <= sel_shift_adr;
            bus.correct_shift_valid    <= fin_shift_valid;
            bus.fwd_hit_o              <= own_hit;
            bus.shift_fwd_hit_o        <= nm_hit;
         end
         if (flush_i) begin
            for (int i = 0; i < FWD_DEPTH; i++) begin
               fwd_hist[i].tag <= 1'b0;
               nm_hist[i].tag  <= 1'b0;
            end
         end
      end
   end

endmodule
